// File: rtl/soam_sprite_reader.sv
// -----------------------------------------------------------------------------
// soam_sprite_reader
//
// Read side of the secondary OAM. After sprite evaluation has filled secondary
// OAM, this block walks it one entry at a time: it issues byte addresses,
// captures the four bytes of each entry (Y, tile, attribute, X) and presents
// the complete entry to the pattern-fetch stage over a valid/ready handshake.
// Done pulses once every entry of the walk has been accepted.
//
// Optional feature macro: SOAM_FILL_EN
//   When defined, every walk covers all slots. Slots at or beyond the sampled
//   count are presented as dummy entries (all bytes 0xFF, Sprite_Dummy=1) and
//   issue no reads. When undefined, only real slots are walked and
//   Sprite_Dummy stays 0.
//
// Ports
//   Clk           clock, rising edge
//   Reset         asynchronous, active-high
//   Start         single-cycle pulse that starts a walk (honoured in IDLE only)
//   Sprite_Count  valid entries in secondary OAM, sampled on Start, saturates
//   SOAM_Data     secondary OAM read data, valid the cycle after SOAM_Rd
//   Fetch_Ready   downstream accepts the presented entry
//   SOAM_Addr     byte address {slot[2:0], byte[1:0]}
//   SOAM_Rd       read strobe
//   Sprite_Y/Tile/Attr/X  captured entry bytes 0..3
//   Sprite_Index  slot number of the presented entry
//   Sprite_Valid  entry presented, held until accepted
//   Sprite_Dummy  presented entry is a filler slot
//   Busy          high whenever not idle
//   Done          one-cycle pulse when the walk completes
// -----------------------------------------------------------------------------
module soam_sprite_reader #(
    parameter int MAX_SPRITES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [3:0] Sprite_Count,
    input  logic [7:0] SOAM_Data,
    input  logic       Fetch_Ready,
    output logic [4:0] SOAM_Addr,
    output logic       SOAM_Rd,
    output logic [7:0] Sprite_Y,
    output logic [7:0] Sprite_Tile,
    output logic [7:0] Sprite_Attr,
    output logic [7:0] Sprite_X,
    output logic [2:0] Sprite_Index,
    output logic       Sprite_Valid,
    output logic       Sprite_Dummy,
    output logic       Busy,
    output logic       Done
);

`ifdef SOAM_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    localparam logic [3:0] MAX_CNT = 4'(MAX_SPRITES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LAST,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [1:0] b_q, b_d;
    logic [7:0] byte_q [4];
    logic [7:0] byte_d [4];
    logic [2:0] index_q, index_d;
    logic       dummy_q, dummy_d;
    logic [4:0] addr_q, addr_d;
    logic       rd_q, rd_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0] start_cnt;
    logic [3:0] start_len;
    logic [3:0] walk_len;
    logic       cur_real;

    always_comb begin
        start_cnt = (Sprite_Count > MAX_CNT) ? MAX_CNT : Sprite_Count;
        start_len = FILL_EN ? MAX_CNT : start_cnt;
        walk_len  = FILL_EN ? MAX_CNT : cnt_q;
        // A slot is real when it lies below the sampled count; only fill mode
        // ever walks past it.
        cur_real  = ({1'b0, idx_q} < cnt_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        b_d     = b_q;
        index_d = index_q;
        dummy_d = dummy_q;
        for (int i = 0; i < 4; i++) begin
            byte_d[i] = byte_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    cnt_d   = start_cnt;
                    idx_d   = 3'd0;
                    b_d     = 2'd0;
                    state_d = (start_len == 4'd0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                // Data returning now belongs to the address issued last cycle.
                if (cur_real && b_q != 2'd0) begin
                    byte_d[b_q - 2'd1] = SOAM_Data;
                end
                if (b_q == 2'd3) begin
                    state_d = S_LAST;
                end else begin
                    b_d = b_q + 2'd1;
                end
            end
            S_LAST: begin
                if (cur_real) begin
                    byte_d[3] = SOAM_Data;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        byte_d[i] = 8'hFF;
                    end
                end
                index_d = idx_q;
                dummy_d = FILL_EN && !cur_real;
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (Fetch_Ready) begin
                    if ({1'b0, idx_q} + 4'd1 == walk_len) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        b_d     = 2'd0;
                        state_d = S_ADDR;
                    end
                end
            end
            S_DONE: begin
                // Start is deliberately not looked at here.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        valid_d = (state_d == S_PRESENT);
        rd_d    = (state_d == S_ADDR) && ({1'b0, idx_d} < cnt_d);
        addr_d  = (state_d == S_ADDR) ? {idx_d, b_d} : addr_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 3'd0;
            b_q     <= 2'd0;
            index_q <= 3'd0;
            dummy_q <= 1'b0;
            addr_q  <= 5'd0;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                byte_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            b_q     <= b_d;
            index_q <= index_d;
            dummy_q <= dummy_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < 4; i++) begin
                byte_q[i] <= byte_d[i];
            end
        end
    end

    assign SOAM_Addr    = addr_q;
    assign SOAM_Rd      = rd_q;
    assign Sprite_Y     = byte_q[0];
    assign Sprite_Tile  = byte_q[1];
    assign Sprite_Attr  = byte_q[2];
    assign Sprite_X     = byte_q[3];
    assign Sprite_Index = index_q;
    assign Sprite_Valid = valid_q;
    assign Sprite_Dummy = dummy_q;
    assign Busy         = busy_q;
    assign Done         = done_q;

endmodule

// File: tb/tb_soam_sprite_reader.sv
// -----------------------------------------------------------------------------
// tb_soam_sprite_reader
//
// Directed and randomized walks of soam_sprite_reader. A behavioural secondary
// OAM returns data one cycle after each read (random garbage otherwise), and a
// reference model derives the expected entries, address list and Done cycle
// from the sprite count, fill mode and the stall applied to each entry.
// -----------------------------------------------------------------------------
module tb_soam_sprite_reader;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [3:0] Sprite_Count = 4'd0;
    logic [7:0] SOAM_Data = 8'd0;
    logic       Fetch_Ready = 1'b0;
    logic [4:0] SOAM_Addr;
    logic       SOAM_Rd;
    logic [7:0] Sprite_Y, Sprite_Tile, Sprite_Attr, Sprite_X;
    logic [2:0] Sprite_Index;
    logic       Sprite_Valid, Sprite_Dummy, Busy, Done;

    int errors = 0;
    int checks = 0;

`ifdef SOAM_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    logic [7:0] mem [32];
    bit         pend_rd = 1'b0;
    logic [4:0] pend_addr = 5'd0;

    soam_sprite_reader #(.MAX_SPRITES(8)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Sprite_Count (Sprite_Count),
        .SOAM_Data    (SOAM_Data),
        .Fetch_Ready  (Fetch_Ready),
        .SOAM_Addr    (SOAM_Addr),
        .SOAM_Rd      (SOAM_Rd),
        .Sprite_Y     (Sprite_Y),
        .Sprite_Tile  (Sprite_Tile),
        .Sprite_Attr  (Sprite_Attr),
        .Sprite_X     (Sprite_X),
        .Sprite_Index (Sprite_Index),
        .Sprite_Valid (Sprite_Valid),
        .Sprite_Dummy (Sprite_Dummy),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    // Secondary OAM: the request seen in a cycle is answered in the next one.
    always @(negedge Clk) begin
        pend_rd   = SOAM_Rd;
        pend_addr = SOAM_Addr;
    end

    always @(posedge Clk) begin
        #1;
        if (pend_rd) SOAM_Data = mem[pend_addr];
        else         SOAM_Data = 8'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    endtask

    task automatic check_reset(input string name);
        check({name, ".addr_rd"}, {SOAM_Addr, SOAM_Rd}, 32'h0);
        check({name, ".bytes"}, {Sprite_Y, Sprite_Tile, Sprite_Attr, Sprite_X}, 32'h0);
        check({name, ".idx_val_dum"}, {Sprite_Index, Sprite_Valid, Sprite_Dummy}, 32'h0);
        check({name, ".busy_done"}, {Busy, Done}, 32'h0);
    endtask

    task automatic do_walk(input string name, input int cnt, input int stall,
                           input bit busy_start, input bit done_start);
        int sat, n, k, st, cyc, done_cyc;
        bit done_seen;
        logic [4:0]  addrs[$];
        logic [31:0] exp_bytes[$];
        logic [31:0] exp_tag[$];

        sat = (cnt > 8) ? 8 : cnt;
        n   = FILL ? 8 : sat;
        for (int i = 0; i < n; i++) begin
            if (i < sat) begin
                exp_bytes.push_back({mem[4*i], mem[4*i+1], mem[4*i+2], mem[4*i+3]});
                exp_tag.push_back(32'(i));
            end else begin
                exp_bytes.push_back(32'hFFFF_FFFF);
                exp_tag.push_back(32'(i) | 32'h8);
            end
        end

        k = 0; st = 0; done_seen = 1'b0; done_cyc = -1;
        @(negedge Clk);
        Start = 1'b1; Sprite_Count = 4'(cnt); Fetch_Ready = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        cyc = 1;
        check({name, ".busy_T+1"}, Busy, 1);

        while (!done_seen && cyc < 400) begin
            if (busy_start) begin
                if (cyc == 3) begin
                    Start = 1'b1; Sprite_Count = 4'd1;
                end else if (cyc == 4) begin
                    Start = 1'b0; Sprite_Count = 4'(cnt);
                end
            end
            if (SOAM_Rd) addrs.push_back(SOAM_Addr);
            if (Done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                if (done_start) begin
                    Start = 1'b1; Sprite_Count = 4'd3;
                end
            end
            if (Sprite_Valid) begin
                if (k < n) begin
                    check({name, ".bytes"}, {Sprite_Y, Sprite_Tile, Sprite_Attr, Sprite_X}, exp_bytes[k]);
                    check({name, ".dummy_index"}, {28'd0, Sprite_Dummy, Sprite_Index}, exp_tag[k]);
                end else begin
                    check({name, ".extra_entry"}, k, n - 1);
                end
                if (st < stall) begin
                    Fetch_Ready = 1'b0;
                    st++;
                end else begin
                    Fetch_Ready = 1'b1;
                    k++;
                    st = 0;
                end
            end else begin
                Fetch_Ready = 1'($urandom_range(0, 1));
            end
            @(negedge Clk);
            cyc++;
        end
        Start = 1'b0;
        Sprite_Count = 4'(cnt);

        check({name, ".done_cycle"}, done_cyc, 1 + n * (6 + stall));
        check({name, ".done_pulse"}, Done, 0);
        check({name, ".idle_after"}, Busy, 0);
        check({name, ".entries"}, k, n);
        check({name, ".reads"}, addrs.size(), 4 * sat);
        for (int i = 0; i < addrs.size() && i < 4 * sat; i++) begin
            check({name, ".addr"}, addrs[i], i);
        end
        $display("walk %s count=%0d stall=%0d entries=%0d reads=%0d done_at=%0d",
                 name, cnt, stall, k, addrs.size(), done_cyc);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        check_reset("init");
        Reset = 1'b0;

        // Known bytes for the first two entries.
        rand_mem();
        for (int i = 0; i < 8; i++) mem[i] = 8'((i + 1) * 16);
        do_walk("two_entries", 2, 0, 1'b0, 1'b0);

        rand_mem();
        do_walk("stall5", 1, 5, 1'b0, 1'b0);

        rand_mem();
        do_walk("saturate12", 12, 0, 1'b0, 1'b0);

        rand_mem();
        do_walk("count0", 0, 0, 1'b0, 1'b0);

        // Reset while entry 1 is being read.
        rand_mem();
        Fetch_Ready = 1'b1;
        @(negedge Clk);
        Start = 1'b1; Sprite_Count = 4'd3;
        @(negedge Clk);
        Start = 1'b0;
        repeat (7) @(negedge Clk);
        check("rst.pre_read", {SOAM_Rd, SOAM_Addr}, {1'b1, 5'd5});
        #1 Reset = 1'b1;
        #1 check_reset("rst.mid");
        @(negedge Clk);
        check("rst.no_done", {Done, Busy}, 0);
        Reset = 1'b0;
        do_walk("after_rst", 1, 0, 1'b0, 1'b0);

        rand_mem();
        do_walk("start_busy", 3, 0, 1'b1, 1'b0);

        rand_mem();
        do_walk("start_on_done", 5, 1, 1'b0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            rand_mem();
            do_walk("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                    1'b0, 1'(r % 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
